// File: rtl/sync_search_controller.sv
// Synchronisation search sequencer: sweeps LLR phase x depuncture offset hypotheses and
// declares/drops lock on runs of good/bad windows. Optional stats outputs: SYNC_CTRL_STATS_EN.
module sync_search_controller #(
  parameter int PHASE_NUM  = 4,
  parameter int DEPERF_NUM = 2,
  parameter int CNT_W      = 8,
  localparam int PH_W = $clog2(PHASE_NUM),
  localparam int DP_W = (DEPERF_NUM > 1) ? $clog2(DEPERF_NUM) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_period_done,
  input  logic             i_period_good,
  input  logic [CNT_W-1:0] i_settle_periods,
  input  logic [CNT_W-1:0] i_confirm_periods,
  input  logic [CNT_W-1:0] i_loss_periods,
  output logic             o_llr_reset,
  output logic             o_next_phase,
  output logic             o_deperf_next_st,
  output logic             o_is_sync,
  output logic [PH_W-1:0]  o_phase_idx,
  output logic [DP_W-1:0]  o_deperf_idx,
  output logic             o_sweep_done
`ifdef SYNC_CTRL_STATS_EN
  ,
  output logic [15:0]      o_sweep_cnt,
  output logic [15:0]      o_loss_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, START, SETTLE, EVAL, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [DP_W-1:0]  deperf_q, deperf_d;
  logic             llr_reset_q, llr_reset_d;
  logic             next_phase_q, next_phase_d;
  logic             deperf_next_q, deperf_next_d;
  logic             is_sync_q, is_sync_d;
  logic             sweep_done_q, sweep_done_d;

  logic [CNT_W-1:0] confirm_eff, loss_eff, good_inc, bad_inc, settle_inc;
  logic             settle_zero;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign confirm_eff = (i_confirm_periods == '0) ? CNT_W'(1) : i_confirm_periods;
  assign loss_eff    = (i_loss_periods == '0) ? CNT_W'(1) : i_loss_periods;
  assign settle_zero = (i_settle_periods == '0);
  assign good_inc    = sat_inc(good_cnt_q);
  assign bad_inc     = sat_inc(bad_cnt_q);
  assign settle_inc  = sat_inc(settle_cnt_q);

  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    good_cnt_d    = good_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    phase_d       = phase_q;
    deperf_d      = deperf_q;
    is_sync_d     = is_sync_q;
    llr_reset_d   = 1'b0;
    next_phase_d  = 1'b0;
    deperf_next_d = 1'b0;
    sweep_done_d  = 1'b0;
    if (!i_enable) begin
      state_d      = IDLE;
      settle_cnt_d = '0;
      good_cnt_d   = '0;
      bad_cnt_d    = '0;
      is_sync_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = START;
          is_sync_d = 1'b0;
        end
        START: begin
          llr_reset_d  = 1'b1;
          phase_d      = '0;
          deperf_d     = '0;
          settle_cnt_d = '0;
          good_cnt_d   = '0;
          bad_cnt_d    = '0;
          is_sync_d    = 1'b0;
          state_d      = settle_zero ? EVAL : SETTLE;
        end
        SETTLE: begin
          if (settle_zero) begin
            state_d = EVAL;
          end else if (i_period_done) begin
            if (settle_inc >= i_settle_periods) begin
              state_d      = EVAL;
              settle_cnt_d = '0;
            end else begin
              settle_cnt_d = settle_inc;
            end
          end
        end
        EVAL: begin
          if (i_period_done) begin
            if (i_period_good) begin
              good_cnt_d = good_inc;
              if (good_inc >= confirm_eff) begin
                state_d    = LOCKED;
                good_cnt_d = '0;
                bad_cnt_d  = '0;
                is_sync_d  = 1'b1;
              end
            end else begin
              // Bad window: step to the next phase; phase wrap carries into the offset.
              good_cnt_d   = '0;
              settle_cnt_d = '0;
              state_d      = settle_zero ? EVAL : SETTLE;
              next_phase_d = 1'b1;
              if (phase_q == PH_W'(PHASE_NUM - 1)) begin
                phase_d       = '0;
                deperf_next_d = 1'b1;
                if (deperf_q == DP_W'(DEPERF_NUM - 1)) begin
                  deperf_d     = '0;
                  sweep_done_d = 1'b1;
                  llr_reset_d  = 1'b1;
                end else begin
                  deperf_d = deperf_q + 1'b1;
                end
              end else begin
                phase_d = phase_q + 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          is_sync_d = 1'b1;
          if (i_period_done) begin
            if (i_period_good) begin
              bad_cnt_d = '0;
            end else if (bad_inc >= loss_eff) begin
              bad_cnt_d = '0;
              is_sync_d = 1'b0;
              state_d   = START;
            end else begin
              bad_cnt_d = bad_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      settle_cnt_q  <= '0;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      phase_q       <= '0;
      deperf_q      <= '0;
      llr_reset_q   <= 1'b0;
      next_phase_q  <= 1'b0;
      deperf_next_q <= 1'b0;
      is_sync_q     <= 1'b0;
      sweep_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      phase_q       <= phase_d;
      deperf_q      <= deperf_d;
      llr_reset_q   <= llr_reset_d;
      next_phase_q  <= next_phase_d;
      deperf_next_q <= deperf_next_d;
      is_sync_q     <= is_sync_d;
      sweep_done_q  <= sweep_done_d;
    end
  end

  assign o_llr_reset      = llr_reset_q;
  assign o_next_phase     = next_phase_q;
  assign o_deperf_next_st = deperf_next_q;
  assign o_is_sync        = is_sync_q;
  assign o_phase_idx      = phase_q;
  assign o_deperf_idx     = deperf_q;
  assign o_sweep_done     = sweep_done_q;

`ifdef SYNC_CTRL_STATS_EN
  logic [15:0] sweep_cnt_q, loss_cnt_q;
  logic        lost;

  assign lost = (state_q == LOCKED) && (state_d == START);

  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_cnt_q <= '0;
      loss_cnt_q  <= '0;
    end else begin
      if (sweep_done_d && !(&sweep_cnt_q)) sweep_cnt_q <= sweep_cnt_q + 1'b1;
      if (lost && !(&loss_cnt_q))          loss_cnt_q  <= loss_cnt_q + 1'b1;
    end
  end

  assign o_sweep_cnt = sweep_cnt_q;
  assign o_loss_cnt  = loss_cnt_q;
`endif

endmodule

// File: tb/tb_sync_search_controller.sv
// Bench for sync_search_controller: directed vector table plus randomized run against a
// hypothesis-index reference model (stats ports checked when SYNC_CTRL_STATS_EN is defined).
module tb_sync_search_controller;
  localparam int P = 4;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       reset, i_enable, i_period_done, i_period_good;
  logic [7:0] i_settle_periods, i_confirm_periods, i_loss_periods;
  logic       o_llr_reset, o_next_phase, o_deperf_next_st, o_is_sync, o_sweep_done;
  logic [1:0] o_phase_idx;
  logic [0:0] o_deperf_idx;
`ifdef SYNC_CTRL_STATS_EN
  logic [15:0] o_sweep_cnt, o_loss_cnt;
`endif

  always #5 clk = ~clk;

  sync_search_controller #(.PHASE_NUM(P), .DEPERF_NUM(D), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable),
    .i_period_done(i_period_done), .i_period_good(i_period_good),
    .i_settle_periods(i_settle_periods), .i_confirm_periods(i_confirm_periods),
    .i_loss_periods(i_loss_periods),
    .o_llr_reset(o_llr_reset), .o_next_phase(o_next_phase),
    .o_deperf_next_st(o_deperf_next_st), .o_is_sync(o_is_sync),
    .o_phase_idx(o_phase_idx), .o_deperf_idx(o_deperf_idx),
    .o_sweep_done(o_sweep_done)
`ifdef SYNC_CTRL_STATS_EN
    , .o_sweep_cnt(o_sweep_cnt), .o_loss_cnt(o_loss_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // {llr_reset, next_phase, deperf_next, sweep_done, is_sync, phase[1:0], deperf[0]}
  function automatic logic [7:0] act_vec();
    return {o_llr_reset, o_next_phase, o_deperf_next_st, o_sweep_done, o_is_sync,
            o_phase_idx, o_deperf_idx};
  endfunction

  typedef struct {
    bit         rst, en, d, g;
    logic [7:0] st, cf, ls;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic [7:0] t_st, t_cf, t_ls;

  task automatic add(input bit rst, en, d, g, input bit llr, np, dn, sw, sy,
                     input int ph, input int dp);
    vec_t v;
    v.rst = rst; v.en = en; v.d = d; v.g = g;
    v.st = t_st; v.cf = t_cf; v.ls = t_ls;
    v.exp = {llr, np, dn, sw, sy, 2'(ph), 1'(dp)};
    tbl.push_back(v);
  endtask

  // Reference model: one flat hypothesis index h in [0, P*D), phase = h%P, offset = h/P.
  localparam int M_IDLE = 0, M_START = 1, M_HUNT = 2, M_LOCK = 3;
  int m_mode, m_h, m_disc, m_grun, m_brun, m_swc, m_lc;
  bit m_sync, e_llr, e_np, e_dn, e_sw;

  function automatic int atleast1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_step(input bit rst, en, d, g);
    e_llr = 0; e_np = 0; e_dn = 0; e_sw = 0;
    if (rst) begin
      m_mode = M_IDLE; m_h = 0; m_disc = 0; m_grun = 0; m_brun = 0;
      m_sync = 0; m_swc = 0; m_lc = 0;
    end else if (!en) begin
      m_mode = M_IDLE; m_sync = 0;
    end else begin
      case (m_mode)
        M_IDLE: m_mode = M_START;
        M_START: begin
          e_llr = 1; m_h = 0; m_grun = 0; m_brun = 0;
          m_disc = int'(i_settle_periods); m_mode = M_HUNT;
        end
        M_HUNT: if (d) begin
          if (m_disc > 0) m_disc--;
          else if (g) begin
            m_grun++;
            if (m_grun >= atleast1(int'(i_confirm_periods))) begin
              m_mode = M_LOCK; m_sync = 1; m_brun = 0;
            end
          end else begin
            m_grun = 0; m_disc = int'(i_settle_periods);
            e_np = 1;
            e_dn = ((m_h + 1) % P == 0);
            m_h = (m_h + 1) % (P * D);
            if (m_h == 0) begin
              e_sw = 1; e_llr = 1;
              if (m_swc < 16'hFFFF) m_swc++;
            end
          end
        end
        default: if (d) begin
          if (g) m_brun = 0;
          else begin
            m_brun++;
            if (m_brun >= atleast1(int'(i_loss_periods))) begin
              m_sync = 0; m_mode = M_START;
              if (m_lc < 16'hFFFF) m_lc++;
            end
          end
        end
      endcase
    end
  endtask

  task automatic drive(input bit rst, en, d, g);
    reset = rst; i_enable = en; i_period_done = d; i_period_good = g;
    model_step(rst, en, d, g);
    @(posedge clk); #1;
    chk("model", 32'(act_vec()),
        32'({e_llr, e_np, e_dn, e_sw, m_sync, 2'(m_h % P), 1'(m_h / P)}));
`ifdef SYNC_CTRL_STATS_EN
    chk("sweep_cnt", 32'(o_sweep_cnt), 32'(m_swc));
    chk("loss_cnt", 32'(o_loss_cnt), 32'(m_lc));
`endif
  endtask

  initial begin
    reset = 1; i_enable = 0; i_period_done = 0; i_period_good = 0;
    i_settle_periods = 1; i_confirm_periods = 3; i_loss_periods = 2;
    t_st = 1; t_cf = 3; t_ls = 2;

    // Reset, enable, then an all-bad sweep (settle window before each evaluated one).
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int h = 1; h <= 8; h++) begin
      add(0, 1, 1, 0, 0, 0, 0, 0, 0, (h - 1) % 4, (h - 1) / 4);
      add(0, 1, 1, 0, h == 8, 1, h % 4 == 0, h == 8, 0, h % 4, (h % 8) / 4);
    end
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Walk to phase 2, partial good run, then lock at phase 3.
    for (int h = 1; h <= 2; h++) begin
      add(0, 1, 1, 0, 0, 0, 0, 0, 0, h - 1, 0);
      add(0, 1, 1, 0, 0, 1, 0, 0, 0, h, 0);
    end
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 2, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 2, 0);
    add(0, 1, 1, 0, 0, 1, 0, 0, 0, 3, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 3, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 3, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 1, 3, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    // Locked: isolated bads are forgiven, two in a row drop lock, START follows.
    add(0, 1, 1, 0, 0, 0, 0, 0, 1, 3, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 1, 3, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 1, 3, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 1, 3, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 1, 3, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Enable drop coincident with a bad strobe in EVAL: no pulse.
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // settle=0, confirm=0: one good strobe after START locks.
    t_st = 0; t_cf = 0;
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset mid-operation clears everything at the next edge.
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; i_enable = tbl[i].en;
      i_period_done = tbl[i].d; i_period_good = tbl[i].g;
      i_settle_periods = tbl[i].st; i_confirm_periods = tbl[i].cf;
      i_loss_periods = tbl[i].ls;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), 32'(act_vec()), 32'(tbl[i].exp));
    end

`ifdef SYNC_CTRL_STATS_EN
    i_settle_periods = 1; i_confirm_periods = 3; i_loss_periods = 2;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 32; i++) drive(0, 1, 1, 0);
    drive(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 1);
    drive(0, 1, 1, 0);
    drive(0, 1, 1, 0);
    chk("stats_sweep2", 32'(o_sweep_cnt), 32'd2);
    chk("stats_loss1", 32'(o_loss_cnt), 32'd1);
    drive(1, 0, 0, 0);
    chk("stats_rst_sweep", 32'(o_sweep_cnt), 32'd0);
    chk("stats_rst_loss", 32'(o_loss_cnt), 32'd0);
`endif

    // Randomized segments; thresholds change only while held in reset.
    for (int seg = 0; seg < 6; seg++) begin
      i_settle_periods  = 8'($urandom_range(0, 2));
      i_confirm_periods = 8'($urandom_range(0, 3));
      i_loss_periods    = 8'($urandom_range(0, 3));
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      for (int c = 0; c < 500; c++)
        drive(0, $urandom_range(0, 49) != 0, $urandom_range(0, 1) != 0,
              $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
